// File: rtl/uart_rx_core.sv
// UART receiver core: 8N1 framing, 2-flop input synchronizer, mid-bit sampling,
// sticky frame-error and overrun flags, and a receive buffer.
// Build option: define UART_RX_FIFO_EN for a 4-entry FIFO buffer; otherwise the
// buffer is a single holding register.
module uart_rx_core #(
   parameter int unsigned CLKS_PER_BIT = 4167
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clear_req
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            brk_q;      // low stop seen: wait for line high before next start
   logic            rx_meta_q;
   logic            rx_s_q;

   logic            stop_sample;
   logic            push;
   logic            pop;
   logic            ferr_set;
   logic            ovr_set;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q;
   logic            overrun_q;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Frame FSM: start detect, start-bit confirm, 8 data samples, stop sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         brk_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (rx_s_q) begin
                  brk_q <= 1'b0;
               end else if (!brk_q) begin
                  state_q <= StStart;
                  cnt_q   <= HalfLoad;
               end
            end
            StStart: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else if (!rx_s_q) begin
                  state_q   <= StData;
                  cnt_q     <= BitLoad;
                  bit_idx_q <= '0;
               end else begin
                  state_q <= StIdle;  // glitch, not a real start bit
               end
            end
            StData: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  shift_q   <= {rx_s_q, shift_q[7:1]};
                  cnt_q     <= BitLoad;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= StStop;
                  end
               end
            end
            StStop: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntW'(1);
               end else begin
                  state_q <= StIdle;
                  brk_q   <= ~rx_s_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign stop_sample = (state_q == StStop) && (cnt_q == '0);
   assign push        = stop_sample & rx_s_q;
   assign ferr_set    = stop_sample & ~rx_s_q;
   assign pop         = rx_valid_q & rx_ready;

`ifdef UART_RX_FIFO_EN
   logic [3:0][7:0] mem_q, mem_d;
   logic [1:0]      wr_q, wr_d;
   logic [1:0]      rd_q, rd_d;
   logic [2:0]      count_q, count_d;
   logic            push_ok;

   // FIFO next state; a pop frees the slot so push on full+pop is accepted.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      push_ok = push && ((count_q != 3'd4) || pop);
      ovr_set = push && (count_q == 3'd4) && !pop;
      if (push_ok) begin
         mem_d[wr_q] = shift_q;
         wr_d        = wr_q + 2'd1;
      end
      if (pop) begin
         rd_d = rd_q + 2'd1;
      end
      count_d    = count_q + {2'b00, push_ok} - {2'b00, pop};
      rx_data_d  = mem_d[rd_d];
      rx_valid_d = (count_d != 3'd0);
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
`else
   // Single holding register; full whenever a byte is unread.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovr_set    = 1'b0;
      if (push && (!rx_valid_q || pop)) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
      end else if (pop) begin
         rx_valid_d = 1'b0;
      end
      if (push && rx_valid_q && !pop) begin
         ovr_set = 1'b1;
      end
   end
`endif

   // Registered outputs and sticky flags; a set event beats a clear request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= ferr_set | (frame_err_q & ~clear_req);
         overrun_q   <= ovr_set | (overrun_q & ~clear_req);
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_busy   = (state_q != StIdle);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at CLKS_PER_BIT=16. Works in both builds
// (with or without UART_RX_FIFO_EN).
module tb_uart_rx_core;

   localparam int unsigned Cpb = 16;
   // Posedges from driving the start bit to rx_valid visible: 2 sync stages,
   // 1 idle detect, Cpb/2 start confirm, 8 data bits and the stop bit at Cpb each.
   localparam int ValidLat = 2 + 1 + Cpb / 2 + 9 * Cpb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;
   logic       clear_req = 1'b0;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   bit         auto_mode = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         obs_cyc_q[$];

   uart_rx_core #(.CLKS_PER_BIT(Cpb)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clear_req (clear_req)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every pop while the consumer is always-ready.
   always @(negedge clk) begin
      if (auto_mode && rx_valid && rx_ready) begin
         obs_q.push_back(rx_data);
         obs_cyc_q.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      @(negedge clk);
      rx = 1'b0;
      start_cyc = cyc;
      tick(Cpb);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(Cpb);
      end
      rx = stop_b;
      tick(Cpb);
      rx = 1'b1;
   endtask

   task automatic clear_scoreboard();
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   // Compare one auto-mode pop against the scoreboard head.
   task automatic check_obs(input string name);
      logic [7:0] e, g;
      n_vec++;
      if (obs_q.size() != 1) begin
         n_err++;
         $display("FAIL %s_count: got %0d pops, expected 1", name, obs_q.size());
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      g = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_vec++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s_data: got %02h expected %02h", name, g, e);
      end
   endtask

   // Manual pop: check head, then hold rx_ready for one edge.
   task automatic pop_check(input string name);
      logic [7:0] e;
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_vec++;
      if (rx_valid !== 1'b1 || rx_data !== e) begin
         n_err++;
         $display("FAIL %s: got valid=%b data=%02h expected valid=1 data=%02h",
                  name, rx_valid, rx_data, e);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      tick(3);
      n_vec++;
      if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
         n_err++;
         $display("FAIL reset: got data=%02h v=%b b=%b fe=%b ov=%b expected all 0",
                  rx_data, rx_valid, rx_busy, frame_err, overrun);
      end
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_single();
      int lat;
      auto_mode = 1'b1;
      rx_ready = 1'b1;
      clear_scoreboard();
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1);
      tick(4);
      lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - start_cyc : -1;
      n_vec++;
      if (lat != ValidLat) begin
         n_err++;
         $display("FAIL single_latency: got %0d expected %0d", lat, ValidLat);
      end
      check_obs("single");
      n_vec++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_ferr: got %b expected 0", frame_err);
      end
   endtask

   task automatic test_glitch();
      int busy_n = 0;
      clear_scoreboard();
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         rx = (i < 5) ? 1'b0 : 1'b1;
         if (rx_busy === 1'b1) busy_n++;
      end
      n_vec++;
      if (busy_n < 1 || busy_n > 10) begin
         n_err++;
         $display("FAIL glitch_busy: got %0d busy clks expected 1..10", busy_n);
      end
      n_vec++;
      if (obs_q.size() != 0 || {rx_valid, rx_busy, frame_err, overrun} !== 4'b0000) begin
         n_err++;
         $display("FAIL glitch_state: got pops=%0d v=%b b=%b fe=%b ov=%b expected 0",
                  obs_q.size(), rx_valid, rx_busy, frame_err, overrun);
      end
   endtask

   task automatic test_frame_err();
      clear_scoreboard();
      send_frame(8'h55, 1'b0);
      tick(4);
      n_vec++;
      if (frame_err !== 1'b1 || obs_q.size() != 0) begin
         n_err++;
         $display("FAIL ferr_set: got fe=%b pops=%0d expected fe=1 pops=0",
                  frame_err, obs_q.size());
      end
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      n_vec++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL ferr_clear: got %b expected 0", frame_err);
      end
      tick(4);
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(4);
      check_obs("after_ferr");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      auto_mode = 1'b0;
      rx_ready = 1'b0;
      clear_scoreboard();
      send_frame(8'h3D, 1'b1);
      send_frame(8'h0A, 1'b1);
      tick(4);
`ifdef UART_RX_FIFO_EN
      exp_q.push_back(8'h3D);
      exp_q.push_back(8'h0A);
      pop_check("b2b_pop0");
      pop_check("b2b_pop1");
      n_vec++;
      if (overrun !== 1'b0 || rx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end: got ov=%b v=%b expected 0 0", overrun, rx_valid);
      end
`else
      n_vec++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3D || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_hold: got v=%b data=%02h ov=%b expected 1 3d 1",
                  rx_valid, rx_data, overrun);
      end
`endif
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      rx = 1'b0;
      tick(Cpb);
      rx = 1'b1;
      tick(4 * Cpb + Cpb / 2);
      n_vec++;
      if (rx_busy !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_pre_busy: got %b expected 1", rx_busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
         n_err++;
         $display("FAIL midreset: got data=%02h v=%b b=%b fe=%b ov=%b expected all 0",
                  rx_data, rx_valid, rx_busy, frame_err, overrun);
      end
      rst_n = 1'b1;
      tick(20);
      auto_mode = 1'b1;
      rx_ready = 1'b1;
      clear_scoreboard();
      exp_q.push_back(8'h3D);
      send_frame(8'h3D, 1'b1);
      tick(4);
      check_obs("after_reset");
   endtask

`ifdef UART_RX_FIFO_EN
   task automatic test_fifo_overrun();
      @(negedge clk);
      auto_mode = 1'b0;
      rx_ready = 1'b0;
      clear_scoreboard();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      tick(4);
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL fifo_overrun: got %b expected 1", overrun);
      end
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 4; i++) pop_check("fifo_pop");
      @(negedge clk);
      n_vec++;
      if (rx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fifo_empty: got %b expected 0", rx_valid);
      end
   endtask
`else
   task automatic test_hold();
      @(negedge clk);
      auto_mode = 1'b0;
      rx_ready = 1'b0;
      clear_scoreboard();
      send_frame(8'h5A, 1'b1);
      tick(50);
      n_vec++;
      if (rx_data !== 8'h5A || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL hold_stable: got data=%02h ov=%b expected 5a 0", rx_data, overrun);
      end
      exp_q.push_back(8'h5A);
      pop_check("hold_pop");
      @(negedge clk);
      n_vec++;
      if (rx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL hold_empty: got %b expected 0", rx_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_RX_FIFO_EN
      test_fifo_overrun();
`else
      test_hold();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
